// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the four-way round-robin arbiter.
package arb_pkg;
    localparam int N_REQ  = 4;
    localparam int IDX_W  = 2;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;
endpackage

// File: rtl/enc_4_2_onehot.sv
// Combinational 4-to-2 one-hot encoder; anything that is not exactly one-hot reports idx=00, valid=0.
module enc_4_2_onehot
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        unique case (onehot)
            4'b0001: begin idx = 2'd0; valid = 1'b1; end
            4'b0010: begin idx = 2'd1; valid = 1'b1; end
            4'b0100: begin idx = 2'd2; valid = 1'b1; end
            4'b1000: begin idx = 2'd3; valid = 1'b1; end
            default: begin idx = '0;   valid = 1'b0; end
        endcase
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant and a bounded hold time
// while other requesters are waiting.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam logic [HOLD_W-1:0] HOLD_LIM  = HOLD_W'(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]  last_q, last_d;

    // Returns {found, index}: first set candidate in order last+1, last+2, last+3, last.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] cand,
                                               input logic [IDX_W-1:0] last);
        logic             found;
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] pos;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = last + IDX_W'(k);
            if (!found && cand[pos]) begin
                found = 1'b1;
                win   = pos;
            end
        end
        return {found, win};
    endfunction

    logic [IDX_W:0]   pick_all;
    logic [IDX_W:0]   pick_other;
    logic [N_REQ-1:0] others;
    logic             owner_req;

    always_comb begin
        others     = req & ~gnt_q;
        owner_req  = req[last_q];
        pick_all   = rr_pick(req, last_q);
        pick_other = rr_pick(others, last_q);

        state_d    = state_q;
        gnt_d      = gnt_q;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;

        unique case (state_q)
            IDLE: begin
                if (pick_all[IDX_W]) begin
                    state_d    = GRANT;
                    gnt_d      = N_REQ'(1) << pick_all[IDX_W-1:0];
                    hold_cnt_d = '0;
                    last_d     = pick_all[IDX_W-1:0];
                end
            end
            GRANT: begin
                // last_q always names the current owner while in GRANT.
                if (owner_req && !pick_other[IDX_W]) begin
                    if (hold_cnt_q < HOLD_LIM)
                        hold_cnt_d = hold_cnt_q + 1'b1;
                end else if (owner_req && hold_cnt_q < HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end else if (pick_other[IDX_W]) begin
                    // Forced rotation (hold expired, including a saturated count) or voluntary handover.
                    gnt_d      = N_REQ'(1) << pick_other[IDX_W-1:0];
                    hold_cnt_d = '0;
                    last_d     = pick_other[IDX_W-1:0];
                end else begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            hold_cnt_q <= '0;
            last_q     <= 2'd3;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
        end
    end

    assign gnt = gnt_q;

    enc_4_2_onehot u_enc (
        .onehot (gnt_q),
        .idx    (gnt_idx),
        .valid  (gnt_valid)
    );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 (HOLD_MAX=4) and the standalone one-hot encoder.
module tb_rr_arbiter_4;
    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    logic [3:0] enc_in;
    logic [1:0] enc_idx;
    logic       enc_valid;

    int checks;
    int errors;

    rr_arbiter_4 #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    enc_4_2_onehot u_enc (
        .onehot (enc_in),
        .idx    (enc_idx),
        .valid  (enc_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [3:0] exp_gnt,
                             input logic [1:0] exp_idx, input logic exp_valid);
        checks++;
        if (gnt !== exp_gnt || gnt_idx !== exp_idx || gnt_valid !== exp_valid) begin
            errors++;
            $display("FAIL %s: got gnt=%b idx=%b valid=%b, expected gnt=%b idx=%b valid=%b",
                     name, gnt, gnt_idx, gnt_valid, exp_gnt, exp_idx, exp_valid);
        end else begin
            $display("ok   %s: gnt=%b idx=%b valid=%b", name, gnt, gnt_idx, gnt_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0000;
        #2;
        check_out("reset_async", 4'b0000, 2'b00, 1'b0);
        tick();
        check_out("reset_held", 4'b0000, 2'b00, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_single();
        req = 4'b0100;
        tick();
        check_out("single_first", 4'b0100, 2'b10, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_out($sformatf("single_hold_%0d", i), 4'b0100, 2'b10, 1'b1);
        end
    endtask

    task automatic test_release();
        req = 4'b0000;
        tick();
        check_out("release_idle", 4'b0000, 2'b00, 1'b0);
        tick();
        check_out("release_stay_idle", 4'b0000, 2'b00, 1'b0);
    endtask

    task automatic test_contention();
        logic [3:0] exp_gnt;
        logic [1:0] exp_idx;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 18; i++) begin
            exp_idx = 2'((i / 4) % 4);
            exp_gnt = 4'b0001 << exp_idx;
            tick();
            check_out($sformatf("contention_cyc%0d", i), exp_gnt, exp_idx, 1'b1);
        end
    endtask

    task automatic test_saturated_rotation();
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 7; i++) tick();
        check_out("sat_alone", 4'b0001, 2'b00, 1'b1);
        req = 4'b0011;
        tick();
        check_out("sat_rotate", 4'b0010, 2'b01, 1'b1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0011;
        tick();
        check_out("b2b_first", 4'b0001, 2'b00, 1'b1);
        tick();
        check_out("b2b_hold1", 4'b0001, 2'b00, 1'b1);
        req = 4'b0010;
        tick();
        check_out("b2b_handover", 4'b0010, 2'b01, 1'b1);
        // Owner 1 drops while 0 and 3 arrive on the same edge: search 2,3,0 picks 3.
        req = 4'b1001;
        tick();
        check_out("b2b_new_req", 4'b1000, 2'b11, 1'b1);
    endtask

    task automatic test_async_reset_mid_grant();
        check_out("async_pre", 4'b1000, 2'b11, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check_out("async_drop", 4'b0000, 2'b00, 1'b0);
        req = 4'b1001;
        #2;
        rst = 1'b0;
        tick();
        check_out("async_first_after", 4'b0001, 2'b00, 1'b1);
    endtask

    task automatic test_encoder();
        logic [1:0] exp_idx;
        logic       exp_valid;
        for (int v = 0; v < 16; v++) begin
            enc_in = 4'(v);
            case (v)
                1:       begin exp_idx = 2'b00; exp_valid = 1'b1; end
                2:       begin exp_idx = 2'b01; exp_valid = 1'b1; end
                4:       begin exp_idx = 2'b10; exp_valid = 1'b1; end
                8:       begin exp_idx = 2'b11; exp_valid = 1'b1; end
                default: begin exp_idx = 2'b00; exp_valid = 1'b0; end
            endcase
            #1;
            checks++;
            if (enc_idx !== exp_idx || enc_valid !== exp_valid) begin
                errors++;
                $display("FAIL enc_%b: got idx=%b valid=%b, expected idx=%b valid=%b",
                         enc_in, enc_idx, enc_valid, exp_idx, exp_valid);
            end else begin
                $display("ok   enc_%b: idx=%b valid=%b", enc_in, enc_idx, enc_valid);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        req    = 4'b0000;
        enc_in = 4'b0000;
        test_reset();
        test_single();
        test_release();
        test_contention();
        test_saturated_rotation();
        test_back_to_back();
        test_async_reset_mid_grant();
        test_encoder();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
